// File: rtl/register_file_if.sv
// Bus bundle for the three-read/one-write register file: read addresses and data,
// plus the write address, data and strobe.
interface register_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] Read1;
    logic [ADDR_W-1:0] Read2;
    logic [ADDR_W-1:0] Read3;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] Data;
    logic              WriteEnable;
    logic [DATA_W-1:0] Out1;
    logic [DATA_W-1:0] Out2;
    logic [DATA_W-1:0] Out3;

    modport master (
        output Read1, Read2, Read3, WriteReg, Data, WriteEnable,
        input  Out1, Out2, Out3
    );

    modport slave (
        input  Read1, Read2, Read3, WriteReg, Data, WriteEnable,
        output Out1, Out2, Out3
    );
endinterface

// File: rtl/register_file.sv
// 2^ADDR_W x DATA_W register file: three combinational reads, one clocked write, r0 = 0.
// Define REGFILE_BYPASS_EN to forward in-flight write data onto matching read ports.
module register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input logic            clk,
    input logic            Reset,
    register_file_if.slave bus
);
    localparam int NUM_REGS  = 1 << ADDR_W;
    localparam int NUM_PORTS = 3;

    logic [DATA_W-1:0] regs      [NUM_REGS];
    logic [ADDR_W-1:0] read_addr [NUM_PORTS];
    logic [DATA_W-1:0] read_data [NUM_PORTS];

    assign read_addr[0] = bus.Read1;
    assign read_addr[1] = bus.Read2;
    assign read_addr[2] = bus.Read3;

    assign bus.Out1 = read_data[0];
    assign bus.Out2 = read_data[1];
    assign bus.Out3 = read_data[2];

    // Flop storage with async clear; entry 0 has no storage at all.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        if (gi == 0) begin : g_zero
            assign regs[gi] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] value_reg;

            always_ff @(posedge clk or negedge Reset) begin
                if (!Reset) begin
                    value_reg <= '0;
                end else if (bus.WriteEnable == 1'b1 && bus.WriteReg == ADDR_W'(gi)) begin
                    value_reg <= bus.Data;
                end
            end

            assign regs[gi] = value_reg;
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_read
        logic [DATA_W-1:0] port_data;

        always_comb begin
            port_data = regs[read_addr[gi]];
`ifdef REGFILE_BYPASS_EN
            if (bus.WriteEnable == 1'b1 && bus.WriteReg != '0 && read_addr[gi] == bus.WriteReg) begin
                port_data = bus.Data;
            end
`endif
            // Storage is already clear during reset; gating also masks any bypass path.
            if (!Reset) begin
                port_data = '0;
            end
        end

        assign read_data[gi] = port_data;
    end
endmodule

// File: tb/tb_register_file.sv
// Randomised scoreboard bench for register_file: stimulus pushes expected reads,
// a negedge monitor pops and compares against the live outputs.
module tb_register_file;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 1 << ADDR_W;

    logic clk;
    logic Reset;

    register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
        logic [DATA_W-1:0] e3;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] model [NREGS];
    int                checks = 0;
    int                passes = 0;
    int                txn    = 0;

    // What a read of addr should return right now, from the architectural rules.
    function automatic logic [DATA_W-1:0] expect_read(input logic [ADDR_W-1:0] addr);
        if (Reset !== 1'b1) return '0;
        if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (bus.WriteEnable === 1'b1 && bus.WriteReg == addr) return bus.Data;
`endif
        return model[addr];
    endfunction

    task automatic push_expect(input string tag);
        exp_t e;
        e.tag = tag;
        e.e1  = expect_read(bus.Read1);
        e.e2  = expect_read(bus.Read2);
        e.e3  = expect_read(bus.Read3);
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs, queue the expectation, then commit the write at the edge.
    task automatic drive(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                         input logic [ADDR_W-1:0] r3, input logic we,
                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] d,
                         input string tag);
        bus.Read1 = r1; bus.Read2 = r2; bus.Read3 = r3;
        bus.WriteEnable = we; bus.WriteReg = wa; bus.Data = d;
        push_expect(tag);
        @(posedge clk);
        if (Reset === 1'b1 && we && wa != 0) model[wa] = d;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    // Hold reset across two edges while attempting a write, then release mid-period.
    task automatic reset_pulse(input string tag);
        #1;
        Reset = 1'b0;
        clear_model();
        bus.WriteEnable = 1'b1; bus.WriteReg = 4'd5; bus.Data = 16'hBEEF;
        push_expect({tag, "_now"});
        @(posedge clk); #1;
        bus.Read1 = 4'd5; bus.Read2 = 4'd1; bus.Read3 = 4'd15;
        push_expect({tag, "_held"});
        @(posedge clk); #2;
        Reset = 1'b1;
        bus.WriteEnable = 1'b0;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            logic ok;
            e  = sb_q.pop_front();
            ok = 1'b1;
            txn++;
            checks += 3;
            if (bus.Out1 !== e.e1) begin
                ok = 1'b0;
                $display("FAIL %s Out1: got %0d expected %0d", e.tag, bus.Out1, e.e1);
            end else passes++;
            if (bus.Out2 !== e.e2) begin
                ok = 1'b0;
                $display("FAIL %s Out2: got %0d expected %0d", e.tag, bus.Out2, e.e2);
            end else passes++;
            if (bus.Out3 !== e.e3) begin
                ok = 1'b0;
                $display("FAIL %s Out3: got %0d expected %0d", e.tag, bus.Out3, e.e3);
            end else passes++;
            if (ok) $display("txn %0d %s: Out1=%0d Out2=%0d Out3=%0d ok", txn, e.tag, bus.Out1, bus.Out2, bus.Out3);
        end
    end

    initial begin
        Reset = 1'b0;
        bus.Read1 = 4'd1; bus.Read2 = 4'd2; bus.Read3 = 4'd3;
        bus.WriteEnable = 1'b0; bus.WriteReg = '0; bus.Data = '0;
        clear_model();

        // 10 ns reset pulse with a write attempt that must be ignored.
        #1;
        bus.WriteEnable = 1'b1; bus.WriteReg = 4'd1; bus.Data = 16'd77;
        push_expect("reset_state");
        #10;
        Reset = 1'b1;
        bus.WriteEnable = 1'b0;
        @(posedge clk); #1;
        drive(4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 16'd0, "after_reset");

        drive(4'd1, 4'd2, 4'd3, 1'b1, 4'd1, 16'd598,  "wr_r1");
        drive(4'd1, 4'd2, 4'd3, 1'b1, 4'd2, 16'd1056, "wr_r2");
        drive(4'd1, 4'd2, 4'd3, 1'b1, 4'd3, 16'd5,    "wr_r3");
        drive(4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 16'd0,    "three_written");

        drive(4'd0, 4'd2, 4'd3, 1'b1, 4'd0, 16'd500, "wr_r0");
        drive(4'd0, 4'd2, 4'd3, 1'b0, 4'd0, 16'd0,   "r0_still_zero");

        drive(4'd1, 4'd2, 4'd3, 1'b0, 4'd2, 16'd7, "we_low");
        drive(4'd1, 4'd2, 4'd3, 1'b0, 4'd2, 16'd7, "we_low_after");

        drive(4'd1, 4'd2, 4'd3, 1'b1, 4'd3, 16'd9, "same_cycle_r3");
        drive(4'd3, 4'd3, 4'd3, 1'b0, 4'd0, 16'd0, "after_edge_r3");

        // Mid-period reset must wipe everything before the next edge.
        reset_pulse("mid_reset");
        drive(4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 16'd0, "post_reset_clear");

        for (int i = 0; i < 300; i++) begin
            logic [ADDR_W-1:0] r1, r2, r3, wa;
            logic              we;
            r1 = ADDR_W'($urandom_range(0, NREGS - 1));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : ADDR_W'($urandom_range(0, NREGS - 1));
            r3 = ($urandom_range(0, 3) == 0) ? r1 : ADDR_W'($urandom_range(0, NREGS - 1));
            we = ($urandom_range(0, 3) != 0);
            wa = ($urandom_range(0, 2) == 0) ? r1 : ADDR_W'($urandom_range(0, NREGS - 1));
            drive(r1, r2, r3, we, wa, DATA_W'($urandom), "random");
            if (i == 150) reset_pulse("random_reset");
        end

        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        else passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
